// File: rtl/axis_noc_inject_if.sv
// AXI-Stream source bundle for the NoC injection mux: NUM_CHANNELS independent
// sources, one packed lane per channel.
interface axis_noc_inject_if #(
  parameter int NUM_CHANNELS = 4,
  parameter int TDATA_WIDTH  = 32,
  parameter int TID_WIDTH    = 2,
  parameter int TDEST_WIDTH  = 2
);
  logic [NUM_CHANNELS-1:0]                  tvalid;
  logic [NUM_CHANNELS-1:0]                  tready;
  logic [NUM_CHANNELS-1:0]                  tlast;
  logic [NUM_CHANNELS-1:0][TDATA_WIDTH-1:0] tdata;
  logic [NUM_CHANNELS-1:0][TID_WIDTH-1:0]   tid;
  logic [NUM_CHANNELS-1:0][TDEST_WIDTH-1:0] tdest;

  modport master (output tvalid, tlast, tdata, tid, tdest, input tready);
  modport slave  (input tvalid, tlast, tdata, tid, tdest, output tready);
endinterface

// File: rtl/axis_noc_inject_mux.sv
// Packet-level round-robin mux of NUM_CHANNELS AXIS sources onto one credit-based
// router injection port. Optional per-channel counters: define AXIS_NOC_INJECT_STATS_EN.

`ifdef AXIS_NOC_INJECT_STATS_EN
module axis_noc_inject_lane_stats (
  input  logic        clk_noc,
  input  logic        rst_n,
  input  logic        flit_hs,
  input  logic        pkt_hs,
  output logic [31:0] flit_count,
  output logic [15:0] pkt_count
);
  always_ff @(posedge clk_noc or negedge rst_n) begin
    if (!rst_n) begin
      flit_count <= '0;
      pkt_count  <= '0;
    end else begin
      if (flit_hs && flit_count != '1) flit_count <= flit_count + 32'd1;
      if (pkt_hs && pkt_count != '1)   pkt_count  <= pkt_count + 16'd1;
    end
  end
endmodule
`endif

module axis_noc_inject_mux #(
  parameter int NUM_CHANNELS      = 4,
  parameter int TDATA_WIDTH       = 32,
  parameter int TID_WIDTH         = 2,
  parameter int TDEST_WIDTH       = 2,
  parameter int DEST_WIDTH        = TID_WIDTH + TDEST_WIDTH,
  parameter int FLIT_BUFFER_DEPTH = 4
) (
  input  logic                   clk_noc,
  input  logic                   rst_n,
  axis_noc_inject_if.slave       axis,
  output logic [TDATA_WIDTH-1:0] data_out,
  output logic [DEST_WIDTH-1:0]  dest_out,
  output logic                   is_tail_out,
  output logic                   send_out,
  input  logic                   credit_in,
  output logic                   credit_err
`ifdef AXIS_NOC_INJECT_STATS_EN
  ,
  output logic [NUM_CHANNELS-1:0][31:0] flit_count,
  output logic [NUM_CHANNELS-1:0][15:0] pkt_count
`endif
);
  localparam int CH_W = $clog2(NUM_CHANNELS);
  localparam int CR_W = $clog2(FLIT_BUFFER_DEPTH + 1);
  localparam logic [CR_W-1:0] CRED_MAX = CR_W'(FLIT_BUFFER_DEPTH);
  localparam logic [CH_W-1:0] LAST_CH  = CH_W'(NUM_CHANNELS - 1);

  typedef enum logic {IDLE, LOCK} state_t;

  state_t                  state, state_nxt;
  logic [CH_W-1:0]         grant, grant_nxt;
  logic [CH_W-1:0]         rr_ptr, rr_nxt;
  logic [CR_W-1:0]         credit_cnt;
  logic                    has_credit;
  logic                    hs;
  logic [NUM_CHANNELS-1:0] ready;

  // First requesting channel at or after p, wrapping; lower offsets win.
  function automatic logic [CH_W-1:0] rr_pick(input logic [NUM_CHANNELS-1:0] v,
                                               input logic [CH_W-1:0] p);
    logic [CH_W-1:0] j;
    rr_pick = p;
    for (int i = NUM_CHANNELS - 1; i >= 0; i--) begin
      j = CH_W'((int'(p) + i) % NUM_CHANNELS);
      if (v[j]) rr_pick = j;
    end
  endfunction

  assign has_credit  = (credit_cnt != '0);
  assign axis.tready = ready;

  always_ff @(posedge clk_noc or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      grant  <= '0;
      rr_ptr <= '0;
    end else begin
      state  <= state_nxt;
      grant  <= grant_nxt;
      rr_ptr <= rr_nxt;
    end
  end

  // Grant is held for the whole packet; ready follows the credit counter directly
  // so a flit can never be accepted without a downstream slot.
  always_comb begin
    state_nxt = state;
    grant_nxt = grant;
    rr_nxt    = rr_ptr;
    ready     = '0;
    hs        = 1'b0;
    case (state)
      IDLE: begin
        if (|axis.tvalid) begin
          grant_nxt = rr_pick(axis.tvalid, rr_ptr);
          state_nxt = LOCK;
        end
      end
      LOCK: begin
        ready[grant] = has_credit;
        hs           = axis.tvalid[grant] & has_credit;
        if (hs && axis.tlast[grant]) begin
          state_nxt = IDLE;
          rr_nxt    = (grant == LAST_CH) ? '0 : grant + CH_W'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_noc or negedge rst_n) begin
    if (!rst_n) begin
      send_out    <= 1'b0;
      data_out    <= '0;
      dest_out    <= '0;
      is_tail_out <= 1'b0;
    end else begin
      send_out <= hs;
      if (hs) begin
        data_out    <= axis.tdata[grant];
        dest_out    <= {axis.tid[grant], axis.tdest[grant]};
        is_tail_out <= axis.tlast[grant];
      end
    end
  end

  // A simultaneous send and credit return cancel out, even when the counter is full.
  always_ff @(posedge clk_noc or negedge rst_n) begin
    if (!rst_n) begin
      credit_cnt <= CRED_MAX;
      credit_err <= 1'b0;
    end else if (hs && !credit_in) begin
      credit_cnt <= credit_cnt - CR_W'(1);
    end else if (credit_in && !hs) begin
      if (credit_cnt == CRED_MAX) credit_err <= 1'b1;
      else                        credit_cnt <= credit_cnt + CR_W'(1);
    end
  end

`ifdef AXIS_NOC_INJECT_STATS_EN
  logic [NUM_CHANNELS-1:0] lane_hs;
  logic [NUM_CHANNELS-1:0] lane_tail;

  assign lane_hs   = hs ? (NUM_CHANNELS'(1) << grant) : '0;
  assign lane_tail = lane_hs & axis.tlast;

  axis_noc_inject_lane_stats u_stats [NUM_CHANNELS-1:0] (
    .clk_noc    (clk_noc),
    .rst_n      (rst_n),
    .flit_hs    (lane_hs),
    .pkt_hs     (lane_tail),
    .flit_count (flit_count),
    .pkt_count  (pkt_count)
  );
`endif
endmodule
